frame_demap: RTL and testbench
==============================

# frame_demap

Receive-side demapper, the counterpart of the sender's map stage. Consumes the incoming line byte stream one byte per valid cycle, tracks frame position with row and column counters, and forwards only payload bytes to the receive payload FIFO. Overhead and end-of-row pad bytes are discarded. Framing loss and payload-FIFO overflow are reported as status.

## Interface
Frame geometry is fixed and not parameterised: 4 rows × 1041 columns.
- Columns 0–15: overhead.
- Columns 16–1039: payload.
- Column 1040: pad.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  synchronous, active-low reset
- i_line_data  in  8  received line byte
- i_line_valid  in  1  i_line_data valid this cycle
- i_line_sof  in  1  start-of-frame marker; qualified by i_line_valid; marks row 0, col 0
- i_pyld_fifo_ready  in  1  payload FIFO can accept a byte this cycle
- o_pyld_data  out  8  payload byte to FIFO
- o_pyld_valid  out  1  o_pyld_data valid (write strobe)
- o_row_cnt  out  2  row of the most recently accepted byte
- o_col_cnt  out  11  column of the most recently accepted byte
- o_locked  out  1  frame alignment held
- o_frame_err  out  1  one-cycle pulse on alignment error
- o_ovf  out  1  sticky payload-drop flag
- o_frame_cnt  out  8  completed-frame count, wraps 255→0

## Operation
State machine, two states.

**HUNT** (reset state)
- Bytes are ignored; counters hold 0.
- On i_line_valid && i_line_sof: accept the byte as (row 0, col 0), move to LOCK, assert o_locked.

**LOCK**
- Each valid byte advances the position:
  - col increments; 1040 → 0 with row increment.
  - Row 3, col 1040 → (0,0).
  - Idle cycles (i_line_valid low) hold the counters.
- Classification by column of the accepted byte:
  - col < 16: overhead, dropped.
  - col 1040: pad, dropped.
  - Otherwise: payload.
- Payload byte with i_pyld_fifo_ready high: forwarded.
- Payload byte with i_pyld_fifo_ready low: dropped and o_ovf set. The line side never stalls; no retry.
- Row 3, col 1040 accepted: o_frame_cnt increments.
- Valid byte with sof at any expected position other than (0,0):
  - Pulse o_frame_err.
  - Re-align: this byte becomes (0,0) as overhead; stay LOCK.
  - o_frame_cnt does not increment.
- Expected position (0,0) with valid byte and no sof:
  - Pulse o_frame_err, go HUNT, deassert o_locked.
  - The byte is dropped and counters clear to 0.

Reset values (i_rst_n low at a clock edge):
- State HUNT.
- All outputs 0: o_pyld_valid, o_locked, o_frame_err, o_ovf, o_frame_cnt, counters, o_pyld_data.
- Reset mid-frame discards all in-flight position; the next sof is required to relock.

## Timing
- All outputs are registered. A byte accepted at edge N appears on o_pyld_data/o_pyld_valid after edge N+1. Latency is 1 cycle.
- o_pyld_valid is high for exactly one cycle per forwarded byte.
- i_pyld_fifo_ready is sampled in the same cycle as the byte (cycle N), not N+1. The FIFO must accept whenever o_pyld_valid is high.
- o_row_cnt/o_col_cnt reflect the position of the byte accepted at N, visible from N+1.
- o_locked changes at N+1 after the triggering byte.
- o_frame_err is high exactly during cycle N+1.
- o_ovf is set at N+1 and cleared only by reset.
- Back-to-back valid bytes are supported at full rate with no bubbles.
- sof without valid is ignored.

## Configuration
Macro `DEMAP_OH_CAPTURE_EN`.

When defined:
- Additional ports: o_oh_data (8, out), o_oh_valid (1, out), o_oh_col (4, out).
- Every overhead byte (col 0–15, any row) accepted in LOCK is presented with the same 1-cycle latency as payload.
- o_oh_col carries the column.
- No backpressure applies to this stream.

When not defined:
- Ports absent; overhead bytes are silently discarded.
- No other behaviour changes.

## Test plan
- **Clean lock.** Reset, then send one full frame (4164 bytes, sof on first).
  - o_locked from cycle 2.
  - Exactly 4096 o_pyld_valid pulses, data matching the payload pattern in order.
  - o_frame_cnt = 1, o_ovf = 0.
- **Gapped input.** Same frame with i_line_valid low every third cycle.
  - Identical 4096-byte output sequence.
  - Counters hold during gaps.
- **Backpressure.** i_pyld_fifo_ready low during the byte at row 1, col 100.
  - That byte is absent from the output.
  - o_ovf = 1 from the next cycle, persisting until reset.
  - Remaining 4095 bytes are correct.
- **Early sof.** sof at row 2, col 500.
  - o_frame_err pulses once, o_locked stays 1.
  - Counters restart at (0,0); next payload forwarded at col 16.
  - o_frame_cnt unchanged.
- **Missing sof.** Second frame starts without sof.
  - o_frame_err pulse, o_locked → 0, no o_pyld_valid until the next sof.
  - After that sof, relock and o_frame_cnt continues from 1.
- **Reset mid-frame, and config build.**
  - Assert i_rst_n = 0 at row 1, col 700: all outputs 0 next cycle, state HUNT.
  - With `DEMAP_OH_CAPTURE_EN`: 64 o_oh_valid pulses per frame, o_oh_col cycling 0–15.

Source files
------------

// File: rtl/frame_demap.sv
// Receive-side frame demapper: tracks row/column of a 4x1041 line frame and forwards payload bytes.
// Optional overhead capture port set enabled by defining DEMAP_OH_CAPTURE_EN.
module frame_demap (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [7:0]  i_line_data,
   input  logic        i_line_valid,
   input  logic        i_line_sof,
   input  logic        i_pyld_fifo_ready,
   output logic [7:0]  o_pyld_data,
   output logic        o_pyld_valid,
   output logic [1:0]  o_row_cnt,
   output logic [10:0] o_col_cnt,
   output logic        o_locked,
   output logic        o_frame_err,
   output logic        o_ovf,
`ifdef DEMAP_OH_CAPTURE_EN
   output logic [7:0]  o_oh_data,
   output logic        o_oh_valid,
   output logic [3:0]  o_oh_col,
`endif
   output logic [7:0]  o_frame_cnt
);

   localparam logic [1:0]  ROW_LAST   = 2'd3;
   localparam logic [10:0] COL_LAST   = 11'd1040;
   localparam logic [10:0] PYLD_FIRST = 11'd16;
   localparam logic [10:0] PYLD_LAST  = 11'd1039;

   typedef enum logic {
      HUNT = 1'b0,
      LOCK = 1'b1
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [1:0]  exp_row;
   logic [10:0] exp_col;
   logic [1:0]  row_nxt;
   logic [10:0] col_nxt;
   logic        accept;
   logic        err_nxt;
   logic        frame_done;
   logic        is_pyld;
   logic        pyld_fwd;
   logic        pyld_drop;
`ifdef DEMAP_OH_CAPTURE_EN
   logic        is_oh;
`endif

   // Expected position of the next byte is derived from the last accepted one.
   always_comb begin
      exp_row    = o_row_cnt;
      exp_col    = o_col_cnt + 11'd1;
      state_nxt  = state;
      row_nxt    = o_row_cnt;
      col_nxt    = o_col_cnt;
      accept     = 1'b0;
      err_nxt    = 1'b0;
      frame_done = 1'b0;

      if (o_col_cnt == COL_LAST) begin
         exp_col = 11'd0;
         exp_row = o_row_cnt + 2'd1;
      end

      case (state)
         HUNT: begin
            if (i_line_valid && i_line_sof) begin
               state_nxt = LOCK;
               row_nxt   = 2'd0;
               col_nxt   = 11'd0;
               accept    = 1'b1;
            end
         end
         LOCK: begin
            if (i_line_valid) begin
               if (exp_row == 2'd0 && exp_col == 11'd0) begin
                  row_nxt = 2'd0;
                  col_nxt = 11'd0;
                  if (i_line_sof) begin
                     accept = 1'b1;
                  end else begin
                     state_nxt = HUNT;
                     err_nxt   = 1'b1;
                  end
               end else if (i_line_sof) begin
                  // Early sof realigns the frame on this byte
                  err_nxt = 1'b1;
                  row_nxt = 2'd0;
                  col_nxt = 11'd0;
                  accept  = 1'b1;
               end else begin
                  row_nxt    = exp_row;
                  col_nxt    = exp_col;
                  accept     = 1'b1;
                  frame_done = (exp_row == ROW_LAST) && (exp_col == COL_LAST);
               end
            end
         end
         default: state_nxt = HUNT;
      endcase

      is_pyld   = accept && (col_nxt >= PYLD_FIRST) && (col_nxt <= PYLD_LAST);
      pyld_fwd  = is_pyld && i_pyld_fifo_ready;
      pyld_drop = is_pyld && !i_pyld_fifo_ready;
`ifdef DEMAP_OH_CAPTURE_EN
      is_oh     = accept && (col_nxt < PYLD_FIRST);
`endif
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state        <= HUNT;
         o_row_cnt    <= 2'd0;
         o_col_cnt    <= 11'd0;
         o_locked     <= 1'b0;
         o_frame_err  <= 1'b0;
         o_pyld_valid <= 1'b0;
         o_pyld_data  <= 8'd0;
         o_ovf        <= 1'b0;
         o_frame_cnt  <= 8'd0;
`ifdef DEMAP_OH_CAPTURE_EN
         o_oh_valid   <= 1'b0;
         o_oh_data    <= 8'd0;
         o_oh_col     <= 4'd0;
`endif
      end else begin
         state        <= state_nxt;
         o_row_cnt    <= row_nxt;
         o_col_cnt    <= col_nxt;
         o_locked     <= (state_nxt == LOCK);
         o_frame_err  <= err_nxt;
         o_pyld_valid <= pyld_fwd;
         if (pyld_fwd) begin
            o_pyld_data <= i_line_data;
         end
         if (pyld_drop) begin
            o_ovf <= 1'b1;
         end
         if (frame_done) begin
            o_frame_cnt <= o_frame_cnt + 8'd1;
         end
`ifdef DEMAP_OH_CAPTURE_EN
         o_oh_valid <= is_oh;
         if (is_oh) begin
            o_oh_data <= i_line_data;
            o_oh_col  <= col_nxt[3:0];
         end
`endif
      end
   end

endmodule

// File: tb/tb_frame_demap.sv
// Scoreboard bench for frame_demap: directed frames with gaps, backpressure, early/missing sof and reset.
`timescale 1ns/1ps
module tb_frame_demap;

   localparam int FRAME_LEN = 4 * 1041;

   logic        i_clk;
   logic        i_rst_n;
   logic [7:0]  i_line_data;
   logic        i_line_valid;
   logic        i_line_sof;
   logic        i_pyld_fifo_ready;
   logic [7:0]  o_pyld_data;
   logic        o_pyld_valid;
   logic [1:0]  o_row_cnt;
   logic [10:0] o_col_cnt;
   logic        o_locked;
   logic        o_frame_err;
   logic        o_ovf;
   logic [7:0]  o_frame_cnt;
`ifdef DEMAP_OH_CAPTURE_EN
   logic [7:0]  o_oh_data;
   logic        o_oh_valid;
   logic [3:0]  o_oh_col;
   logic [11:0] ohQ[$];
   logic [11:0] ohExp;
`endif

   logic [7:0]  pyldQ[$];
   logic [7:0]  expByte;
   int          cmpCount  = 0;
   int          failCount = 0;
   int          errCount  = 0;
   int          errBefore;

   frame_demap dut (
      .i_clk             (i_clk),
      .i_rst_n           (i_rst_n),
      .i_line_data       (i_line_data),
      .i_line_valid      (i_line_valid),
      .i_line_sof        (i_line_sof),
      .i_pyld_fifo_ready (i_pyld_fifo_ready),
      .o_pyld_data       (o_pyld_data),
      .o_pyld_valid      (o_pyld_valid),
      .o_row_cnt         (o_row_cnt),
      .o_col_cnt         (o_col_cnt),
      .o_locked          (o_locked),
      .o_frame_err       (o_frame_err),
      .o_ovf             (o_ovf),
`ifdef DEMAP_OH_CAPTURE_EN
      .o_oh_data         (o_oh_data),
      .o_oh_valid        (o_oh_valid),
      .o_oh_col          (o_oh_col),
`endif
      .o_frame_cnt       (o_frame_cnt)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #5000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [7:0] pat(input int idx, input int salt);
      return 8'((idx * 13) + (salt * 29) + (idx / 251));
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      cmpCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Drives frame positions firstIdx..lastIdx (idx = row*1041 + col) and queues expected outputs
   task automatic applyStimulus(input int firstIdx, input int lastIdx, input bit sofFirst,
                                input int gapEvery, input int bpIdx, input bit expectLocked,
                                input int salt);
      int cyc = 0;
      for (int idx = firstIdx; idx <= lastIdx; idx++) begin
         int row = idx / 1041;
         int col = idx % 1041;
         if (gapEvery > 0 && idx > firstIdx && (cyc % gapEvery) == gapEvery - 1) begin
            i_line_valid      = 1'b0;
            i_line_sof        = 1'b1;
            i_line_data       = 8'hEE;
            i_pyld_fifo_ready = 1'b1;
            @(posedge i_clk); #1;
            if (expectLocked) begin
               checkOutput("gap_hold_col", 32'(o_col_cnt), 32'((idx - 1) % 1041));
               checkOutput("gap_hold_row", 32'(o_row_cnt), 32'((idx - 1) / 1041));
            end
            cyc++;
         end
         i_line_valid      = 1'b1;
         i_line_sof        = sofFirst && (idx == firstIdx);
         i_line_data       = pat(idx, salt);
         i_pyld_fifo_ready = (idx != bpIdx);
         if (expectLocked) begin
            if (col >= 16 && col <= 1039 && idx != bpIdx) pyldQ.push_back(pat(idx, salt));
`ifdef DEMAP_OH_CAPTURE_EN
            if (col < 16) ohQ.push_back({col[3:0], pat(idx, salt)});
`endif
         end
         @(posedge i_clk); #1;
         cyc++;
      end
      i_line_valid = 1'b0;
      i_line_sof   = 1'b0;
   endtask

   always @(negedge i_clk) begin
      if (o_pyld_valid) begin
         if (pyldQ.size() == 0) begin
            checkOutput("pyld_unexpected", 32'(o_pyld_valid), 32'd0);
         end else begin
            expByte = pyldQ.pop_front();
            checkOutput("pyld_data", 32'(o_pyld_data), 32'(expByte));
         end
      end
`ifdef DEMAP_OH_CAPTURE_EN
      if (o_oh_valid) begin
         if (ohQ.size() == 0) begin
            checkOutput("oh_unexpected", 32'(o_oh_valid), 32'd0);
         end else begin
            ohExp = ohQ.pop_front();
            checkOutput("oh_col", 32'(o_oh_col), 32'(ohExp[11:8]));
            checkOutput("oh_data", 32'(o_oh_data), 32'(ohExp[7:0]));
         end
      end
`endif
      if (o_frame_err) errCount++;
   end

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_locked"}, 32'(o_locked), 32'd0);
      checkOutput({tag, "_pyld_valid"}, 32'(o_pyld_valid), 32'd0);
      checkOutput({tag, "_pyld_data"}, 32'(o_pyld_data), 32'd0);
      checkOutput({tag, "_frame_err"}, 32'(o_frame_err), 32'd0);
      checkOutput({tag, "_ovf"}, 32'(o_ovf), 32'd0);
      checkOutput({tag, "_frame_cnt"}, 32'(o_frame_cnt), 32'd0);
      checkOutput({tag, "_row"}, 32'(o_row_cnt), 32'd0);
      checkOutput({tag, "_col"}, 32'(o_col_cnt), 32'd0);
   endtask

   initial begin
      i_rst_n           = 1'b0;
      i_line_valid      = 1'b0;
      i_line_sof        = 1'b0;
      i_line_data       = 8'h00;
      i_pyld_fifo_ready = 1'b1;
      repeat (3) @(posedge i_clk);
      #1;
      checkAllZero("reset");
      i_rst_n = 1'b1;

      // Clean lock
      applyStimulus(0, 0, 1'b1, 0, -1, 1'b1, 1);
      checkOutput("clean_locked", 32'(o_locked), 32'd1);
      applyStimulus(1, FRAME_LEN - 1, 1'b0, 0, -1, 1'b1, 1);
      checkOutput("clean_frame_cnt", 32'(o_frame_cnt), 32'd1);
      checkOutput("clean_ovf", 32'(o_ovf), 32'd0);
      checkOutput("clean_row", 32'(o_row_cnt), 32'd3);
      checkOutput("clean_col", 32'(o_col_cnt), 32'd1040);

      // Gapped input
      applyStimulus(0, FRAME_LEN - 1, 1'b1, 3, -1, 1'b1, 2);
      checkOutput("gap_frame_cnt", 32'(o_frame_cnt), 32'd2);

      // Backpressure at row 1, col 100
      applyStimulus(0, 1041 + 99, 1'b1, 0, -1, 1'b1, 3);
      checkOutput("bp_ovf_before", 32'(o_ovf), 32'd0);
      applyStimulus(1041 + 100, 1041 + 100, 1'b0, 0, 1041 + 100, 1'b1, 3);
      checkOutput("bp_ovf_set", 32'(o_ovf), 32'd1);
      checkOutput("bp_col", 32'(o_col_cnt), 32'd100);
      applyStimulus(1041 + 101, FRAME_LEN - 1, 1'b0, 0, -1, 1'b1, 3);
      checkOutput("bp_ovf_sticky", 32'(o_ovf), 32'd1);
      checkOutput("bp_frame_cnt", 32'(o_frame_cnt), 32'd3);

      // Early sof at row 2, col 500
      applyStimulus(0, 2 * 1041 + 499, 1'b1, 0, -1, 1'b1, 4);
      errBefore = errCount;
      applyStimulus(0, 0, 1'b1, 0, -1, 1'b1, 5);
      checkOutput("early_err", 32'(o_frame_err), 32'd1);
      checkOutput("early_locked", 32'(o_locked), 32'd1);
      checkOutput("early_row", 32'(o_row_cnt), 32'd0);
      checkOutput("early_col", 32'(o_col_cnt), 32'd0);
      checkOutput("early_frame_cnt", 32'(o_frame_cnt), 32'd3);
      applyStimulus(1, FRAME_LEN - 1, 1'b0, 0, -1, 1'b1, 5);
      checkOutput("early_err_once", 32'(errCount), 32'(errBefore + 1));
      checkOutput("early_frame_cnt_end", 32'(o_frame_cnt), 32'd4);

      // Missing sof
      applyStimulus(0, 0, 1'b0, 0, -1, 1'b0, 6);
      checkOutput("miss_err", 32'(o_frame_err), 32'd1);
      checkOutput("miss_locked", 32'(o_locked), 32'd0);
      checkOutput("miss_col", 32'(o_col_cnt), 32'd0);
      applyStimulus(1, FRAME_LEN - 1, 1'b0, 0, -1, 1'b0, 6);
      checkOutput("miss_hunt_locked", 32'(o_locked), 32'd0);
      checkOutput("miss_frame_cnt", 32'(o_frame_cnt), 32'd4);
      applyStimulus(0, FRAME_LEN - 1, 1'b1, 0, -1, 1'b1, 7);
      checkOutput("relock_locked", 32'(o_locked), 32'd1);
      checkOutput("relock_frame_cnt", 32'(o_frame_cnt), 32'd5);

      // Reset mid-frame at row 1, col 700
      applyStimulus(0, 1041 + 700, 1'b1, 0, -1, 1'b1, 8);
      i_rst_n      = 1'b0;
      i_line_valid = 1'b1;
      i_line_data  = 8'h5A;
      @(posedge i_clk); #1;
      checkAllZero("midreset");
      i_rst_n = 1'b1;
      applyStimulus(1041 + 701, FRAME_LEN - 1, 1'b0, 0, -1, 1'b0, 8);
      checkOutput("postreset_locked", 32'(o_locked), 32'd0);
      checkOutput("postreset_col", 32'(o_col_cnt), 32'd0);
      applyStimulus(0, FRAME_LEN - 1, 1'b1, 0, -1, 1'b1, 9);
      checkOutput("postreset_frame_cnt", 32'(o_frame_cnt), 32'd1);
      checkOutput("postreset_ovf", 32'(o_ovf), 32'd0);

      repeat (3) @(posedge i_clk);
      #1;
      checkOutput("pyld_queue_drained", 32'(pyldQ.size()), 32'd0);
`ifdef DEMAP_OH_CAPTURE_EN
      checkOutput("oh_queue_drained", 32'(ohQ.size()), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
      $finish;
   end

endmodule
